demux_1_4_stream: RTL and testbench
===================================

Name: demux_1_4_stream

Overview:
- Streaming 1-to-4 demultiplexer; the routing counterpart of the 4:1 data mux.
- Accepts one W-bit word per valid/ready handshake on a single upstream port.
- Steers each word, by a 2-bit select, into one of four independent output slots.
- Each slot has a one-entry register with its own valid/ready, plus a per-output delivered-word counter for debug/scoreboarding.

Parameters:
- W, 4, data width of every word.
- CNT_W, 8, width of each per-output delivered-word counter (wraps modulo 2**CNT_W).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block can accept the upstream word this cycle.
- in_data  input  W  upstream word.
- in_sel  input  2  destination index 0..3, qualified by in_valid.
- out_valid  output  4  bit i: slot i holds a word.
- out_ready  input  4  bit i: downstream i consumes slot i this cycle.
- out_data  output  4*W  slot i word at bits [i*W +: W].
- out_cnt  output  4*CNT_W  slot i delivered-word count at [i*CNT_W +: CNT_W].

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, every out_data=0, every out_cnt=0. in_ready follows combinationally and is 1 once reset is low, because all slots are empty.
- Upstream acceptance:
  - in_ready = !out_valid[in_sel] || out_ready[in_sel], combinational.
  - A transfer occurs when in_valid && in_ready.
  - in_ready depends only on the addressed slot, so a full, stalled slot k does not block words addressed to other slots once the upstream selects them. The upstream must hold in_data/in_sel stable while in_valid && !in_ready.
- Per-slot state machine, EMPTY/FULL (out_valid[i] is the state):
  - EMPTY + load (transfer with in_sel==i) -> FULL, data latched.
  - FULL + out_ready[i] and no load -> EMPTY.
  - FULL + out_ready[i] + load in the same cycle -> stays FULL with the new data (pass-through, no bubble).
  - FULL + no out_ready[i] -> hold; data must not change.
- Latency: a word accepted in cycle t appears on out_valid/out_data of slot in_sel in cycle t+1.
- Throughput: one word per cycle when the addressed slot's downstream is always ready.
- Ordering: words to the same slot are delivered in acceptance order. No ordering is defined across slots.
- Counters: out_cnt[i] increments by 1 on every out_valid[i] && out_ready[i] cycle and wraps 2**CNT_W-1 -> 0. out_ready asserted while the slot is EMPTY has no effect.
- Loads are one-hot: at most one slot loads per cycle, while any number of slots may drain in the same cycle.
- in_valid=0: no state change except drains. in_sel and in_data are ignored.
- Reset asserted mid-operation: all slots are cleared immediately and all buffered words are discarded, with no handshake. Counters clear.

Decomposition:
- Package demux_pkg:
  - localparam N_OUT=4, localparam SEL_W=2.
  - typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t.
- Sub-module demux_out_slot, one instance per output. Holds the one-entry register, the EMPTY/FULL logic and the wrap counter.
  - Ports: clk, rst, load, load_data, ready_in, valid, data, cnt, can_load.
- Top level:
  - decodes in_sel into one-hot load;
  - muxes can_load by in_sel to form in_ready;
  - generates the four slot instances.

Test Plan:
- Reset then idle: rst pulse mid-simulation with out_valid=4'b0101 -> next sample out_valid=0, out_data=0, out_cnt=0, in_ready=1.
- Single route: in_data=4'hA, in_sel=2, all out_ready=0 -> cycle+1 out_valid=4'b0100, slot2 data=A; slot2 holds A for 5 stall cycles; out_ready[2]=1 for one cycle -> out_valid=0, out_cnt[2]=1.
- Backpressure isolation: slot1 FULL with out_ready[1]=0; offer in_sel=1 -> in_ready=0, slot1 data unchanged; switch to in_sel=3, data=5 -> accepted, slot3=5 next cycle.
- Pass-through: slot0 FULL holding 3, out_ready[0]=1, in_sel=0, data=7 same cycle -> in_ready=1; next cycle slot0=7, still valid, out_cnt[0]+=1.
- Streaming: 16 back-to-back words 0..F with sel=i%4, all out_ready=1 -> in_ready never drops; each slot receives its 4 words in order; each out_cnt=4.
- Counter wrap (CNT_W=8): 256 deliveries on slot 3 -> out_cnt[3]=0. The 255th delivery reads 255.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and slot state encoding for the 1-to-4 streaming demux.
package demux_pkg;

    localparam int N_OUT = 4;
    localparam int SEL_W = 2;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

endpackage

// File: rtl/demux_out_slot.sv
// One output slot: single-entry register with valid/ready and a wrapping
// delivered-word counter.
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [W-1:0]     load_data,
    input  logic             ready_in,
    output logic             valid,
    output logic [W-1:0]     data,
    output logic [CNT_W-1:0] cnt,
    output logic             can_load
);

    slot_state_t state, state_nxt;
    logic        drain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // A full slot being drained this cycle can take a new word without a bubble.
    always_comb begin
        state_nxt = state;
        valid     = (state == SLOT_FULL);
        drain     = valid && ready_in;
        can_load  = !valid || ready_in;
        unique case (state)
            SLOT_EMPTY: if (load) state_nxt = SLOT_FULL;
            SLOT_FULL: begin
                if (load) begin
                    state_nxt = SLOT_FULL;
                end else if (ready_in) begin
                    state_nxt = SLOT_EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (load && can_load) begin
            data <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (drain) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/demux_1_4_stream.sv
// Streaming 1-to-4 demultiplexer: one upstream valid/ready port steered by
// in_sel into four independent single-entry output slots.
module demux_1_4_stream
    import demux_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*W-1:0]     out_data,
    output logic [N_OUT*CNT_W-1:0] out_cnt
);

    logic [N_OUT-1:0] load;
    logic [N_OUT-1:0] can_load;
    logic             xfer;

    // Readiness looks only at the addressed slot, so a stalled slot never blocks others.
    always_comb begin
        in_ready     = can_load[in_sel];
        xfer         = in_valid && in_ready;
        load         = '0;
        load[in_sel] = xfer;
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_slot
        demux_out_slot #(
            .W     (W),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[i]),
            .load_data (in_data),
            .ready_in  (out_ready[i]),
            .valid     (out_valid[i]),
            .data      (out_data[i*W +: W]),
            .cnt       (out_cnt[i*CNT_W +: CNT_W]),
            .can_load  (can_load[i])
        );
    end

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Self-checking bench for demux_1_4_stream: per-slot scoreboard queues plus
// directed checks of routing, backpressure, pass-through, streaming and wrap.
module tb_demux_1_4_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] out_data;
    logic [31:0] out_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [3:0] sb [4][$];
    logic [7:0] mcnt [4];

    demux_1_4_stream #(.W(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    // Negedge monitor: inputs and outputs are stable here and describe the
    // handshakes that the coming rising edge will perform.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                sb[i].delete();
                mcnt[i] = '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                check_eq($sformatf("cnt%0d", i), 32'(out_cnt[i*8 +: 8]), 32'(mcnt[i]));
                if (out_valid[i] && out_ready[i]) begin
                    if (sb[i].size() == 0) begin
                        check_eq($sformatf("unexpected_word%0d", i), 32'(out_valid[i]), 32'd0);
                    end else begin
                        check_eq($sformatf("order%0d", i), 32'(out_data[i*4 +: 4]), 32'(sb[i].pop_front()));
                    end
                    mcnt[i] = mcnt[i] + 8'd1;
                end
            end
            if (in_valid && in_ready) sb[in_sel].push_back(in_data);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        out_ready = 4'b0000;
        drive(1'b0, 2'd0, 4'h0);
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_valid", 32'(out_valid), 32'h0);
        check_eq("rst_data", 32'(out_data), 32'h0);
        check_eq("rst_ready", 32'(in_ready), 32'h1);

        // Single route to slot 2 with stall then one drain
        step();
        drive(1'b1, 2'd2, 4'hA);
        @(negedge clk);
        check_eq("route_ready", 32'(in_ready), 32'h1);
        step();
        drive(1'b0, 2'd0, 4'h0);
        @(negedge clk);
        check_eq("route_valid", 32'(out_valid), 32'h4);
        check_eq("route_data", 32'(out_data[11:8]), 32'hA);
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            check_eq("stall_data", 32'(out_data[11:8]), 32'hA);
            check_eq("stall_valid", 32'(out_valid), 32'h4);
        end
        step();
        out_ready = 4'b0100;
        step();
        out_ready = 4'b0000;
        @(negedge clk);
        check_eq("drain_valid", 32'(out_valid), 32'h0);
        check_eq("drain_cnt2", 32'(out_cnt[23:16]), 32'd1);

        // Backpressure isolation
        drive(1'b1, 2'd1, 4'h6);
        step();
        drive(1'b1, 2'd1, 4'h9);
        @(negedge clk);
        check_eq("bp_ready_blocked", 32'(in_ready), 32'h0);
        step();
        @(negedge clk);
        check_eq("bp_hold", 32'(out_data[7:4]), 32'h6);
        step();
        drive(1'b1, 2'd3, 4'h5);
        @(negedge clk);
        check_eq("bp_ready_other", 32'(in_ready), 32'h1);
        step();
        drive(1'b0, 2'd0, 4'h0);
        @(negedge clk);
        check_eq("bp_valid", 32'(out_valid), 32'hA);
        check_eq("bp_slot3", 32'(out_data[15:12]), 32'h5);
        check_eq("bp_slot1", 32'(out_data[7:4]), 32'h6);
        out_ready = 4'b1111;
        step();
        out_ready = 4'b0000;

        // Pass-through on slot 0
        drive(1'b1, 2'd0, 4'h3);
        step();
        drive(1'b1, 2'd0, 4'h7);
        out_ready = 4'b0001;
        @(negedge clk);
        check_eq("pt_old", 32'(out_data[3:0]), 32'h3);
        check_eq("pt_ready", 32'(in_ready), 32'h1);
        step();
        drive(1'b0, 2'd0, 4'h0);
        out_ready = 4'b0000;
        @(negedge clk);
        check_eq("pt_valid", 32'(out_valid), 32'h1);
        check_eq("pt_data", 32'(out_data[3:0]), 32'h7);
        check_eq("pt_cnt0", 32'(out_cnt[7:0]), 32'd1);

        // Reset mid-operation with slots 0 and 2 holding words
        drive(1'b1, 2'd2, 4'h2);
        step();
        drive(1'b0, 2'd0, 4'h0);
        @(negedge clk);
        check_eq("pre_rst_valid", 32'(out_valid), 32'h5);
        step();
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_valid", 32'(out_valid), 32'h0);
        check_eq("mid_rst_data", 32'(out_data), 32'h0);
        check_eq("mid_rst_cnt", out_cnt, 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", 32'(in_ready), 32'h1);

        // Streaming 16 words, all downstreams ready
        step();
        out_ready = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 2'(k % 4), 4'(k));
            @(negedge clk);
            check_eq("stream_ready", 32'(in_ready), 32'h1);
            step();
        end
        drive(1'b0, 2'd0, 4'h0);
        step();
        @(negedge clk);
        check_eq("stream_valid", 32'(out_valid), 32'h0);
        check_eq("stream_cnts", out_cnt, 32'h04040404);

        // Counter wrap on slot 3 starting from a clean reset
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 4'b1000;
        for (int k = 0; k < 255; k++) begin
            drive(1'b1, 2'd3, 4'(k));
            step();
        end
        drive(1'b0, 2'd0, 4'h0);
        step();
        @(negedge clk);
        check_eq("wrap_255", 32'(out_cnt[31:24]), 32'd255);
        step();
        drive(1'b1, 2'd3, 4'hE);
        step();
        drive(1'b0, 2'd0, 4'h0);
        step();
        @(negedge clk);
        check_eq("wrap_0", 32'(out_cnt[31:24]), 32'd0);
        check_eq("wrap_valid", 32'(out_valid), 32'h0);
        out_ready = 4'b0000;

        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("sb_empty%0d", i), 32'(sb[i].size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
